// File: rtl/nonce_search.sv
// rtl/nonce_search.sv - issues candidate nonces to a fixed-latency hasher and reports the first digest meeting a leading-zero target
module nonce_search #(
    parameter int LATENCY = 65,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [255:0]     base_nonce,
    input  logic [CNT_W-1:0] max_count,
    input  logic [7:0]       difficulty,
    output logic [255:0]     hash_nonce,
    input  logic [255:0]     hash_digest,
    output logic             busy,
    output logic             found_valid,
    input  logic             found_ready,
    output logic [255:0]     found_nonce,
    output logic [255:0]     found_hash,
    output logic             done,
    output logic             exhausted
);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, FIN} state_t;

    state_t             state, state_nx;
    logic [255:0]       base_q;
    logic [CNT_W-1:0]   max_q;
    logic [7:0]         diff_q;
    logic [CNT_W-1:0]   issue_cnt;
    logic [CNT_W-1:0]   result_cnt;
    logic               live;
    logic [LATENCY-1:0] vsr;
    logic               tail;
    logic               match;
    logic               issue_more;
    logic               last_result;

    // live marks that hash_nonce holds a real candidate this cycle; vsr delays that mark to the digest.
    assign tail        = vsr[LATENCY-1];
    assign match       = (hash_digest & ~({256{1'b1}} >> diff_q)) == '0;
    assign issue_more  = issue_cnt < max_q;
    assign last_result = (result_cnt + CNT_W'(1)) == max_q;

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = (max_count == '0) ? FIN : RUN;
            RUN: begin
                busy = 1'b1;
                if (tail) begin
                    if (match)            state_nx = HOLD;
                    else if (last_result) state_nx = FIN;
                end
            end
            HOLD: begin
                busy = 1'b1;
                if (found_valid && found_ready) state_nx = FIN;
            end
            FIN: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q      <= '0;
            max_q       <= '0;
            diff_q      <= '0;
            issue_cnt   <= '0;
            result_cnt  <= '0;
            live        <= 1'b0;
            vsr         <= '0;
            hash_nonce  <= '0;
            found_valid <= 1'b0;
            found_nonce <= '0;
            found_hash  <= '0;
            exhausted   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    base_q     <= base_nonce;
                    max_q      <= max_count;
                    diff_q     <= difficulty;
                    result_cnt <= '0;
                    vsr        <= '0;
                    exhausted  <= (max_count == '0);
                    // The first candidate goes out on the start edge so it is on the bus in the first RUN cycle.
                    if (max_count != '0) begin
                        hash_nonce <= base_nonce;
                        issue_cnt  <= CNT_W'(1);
                        live       <= 1'b1;
                    end else begin
                        issue_cnt  <= '0;
                        live       <= 1'b0;
                    end
                end
                RUN: begin
                    vsr  <= LATENCY'({vsr, live});
                    live <= issue_more;
                    if (issue_more) begin
                        hash_nonce <= base_q + 256'(issue_cnt);
                        issue_cnt  <= issue_cnt + CNT_W'(1);
                    end
                    if (tail) begin
                        if (match) begin
                            found_nonce <= base_q + 256'(result_cnt);
                            found_hash  <= hash_digest;
                            found_valid <= 1'b1;
                        end else begin
                            result_cnt <= result_cnt + CNT_W'(1);
                            if (last_result) exhausted <= 1'b1;
                        end
                    end
                end
                HOLD: if (found_valid && found_ready) found_valid <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nonce_search.sv
// tb/tb_nonce_search.sv - random and directed searches against a lookahead reference model and a delay-line hasher
module tb_nonce_search;

    localparam int LAT = 65;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [255:0] base_nonce = '0;
    logic [31:0]  max_count = '0;
    logic [7:0]   difficulty = '0;
    logic [255:0] hash_nonce;
    logic [255:0] hash_digest;
    logic         busy, found_valid, done, exhausted;
    logic         found_ready = 1'b1;
    logic [255:0] found_nonce, found_hash;

    int n_assert = 0;
    int n_fail = 0;
    int cyc = 0;
    int hmode = 0;
    logic [255:0] pipe [LAT];
    logic [255:0] prev_nonce = '0;
    logic [255:0] nonce_log [$];

    nonce_search #(.LATENCY(LAT), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_nonce(base_nonce),
        .max_count(max_count), .difficulty(difficulty), .hash_nonce(hash_nonce),
        .hash_digest(hash_digest), .busy(busy), .found_valid(found_valid),
        .found_ready(found_ready), .found_nonce(found_nonce), .found_hash(found_hash),
        .done(done), .exhausted(exhausted)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode 0: pseudo-random digest, 1: zero only for nonce 1, 2: never has a leading zero
    function automatic logic [255:0] hfun(logic [255:0] n, int mode);
        logic [31:0] m;
        m = (n[31:0] * 32'h9E3779B1) ^ n[63:32] ^ (n[31:0] >> 7);
        case (mode)
            1:       return (n == 256'd1) ? '0 : {256{1'b1}};
            2:       return {256{1'b1}};
            default: return {8{m}};
        endcase
    endfunction

    function automatic int lz(logic [255:0] h);
        int c = 0;
        bit seen = 1'b0;
        for (int k = 255; k >= 0; k--) begin
            if (h[k]) seen = 1'b1;
            if (!seen) c++;
        end
        return c;
    endfunction

    always @(posedge clk) begin
        pipe[0] <= hash_nonce;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    always_comb hash_digest = hfun(pipe[LAT-1], hmode);

    always @(negedge clk) begin
        if (hash_nonce !== prev_nonce) begin
            nonce_log.push_back(hash_nonce);
            prev_nonce = hash_nonce;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_search(input logic [255:0] b, input int n, input int d,
                             input int hold, input bit poke);
        int idx, t0, rel, fv_cyc, done_cyc;
        bit log_ok;
        logic [255:0] held_nonce, held_hash, held_issue;
        idx = -1;
        for (int i = 0; i < n; i++)
            if (idx < 0 && lz(hfun(b + 256'(i), hmode)) >= d) idx = i;
        found_ready = (hold == 0);
        @(negedge clk);
        nonce_log.delete();
        base_nonce = b; max_count = n; difficulty = 8'(d); start = 1'b1; t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        base_nonce = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        max_count = $urandom_range(0, 3);
        difficulty = 8'($urandom);
        fv_cyc = -1; done_cyc = -1;
        forever begin
            rel = cyc - t0;
            if (found_valid) begin fv_cyc = rel; break; end
            if (done) begin done_cyc = rel; break; end
            if (rel > 400) break;
            start = poke && (rel == 5);
            @(negedge clk);
        end
        start = 1'b0;
        if (idx >= 0) begin
            chk("found_cycle", 256'(fv_cyc), 256'(LAT + 2 + idx));
            chk("found_nonce", found_nonce, b + 256'(idx));
            chk("found_hash", found_hash, hfun(b + 256'(idx), hmode));
            held_nonce = found_nonce; held_hash = found_hash; held_issue = hash_nonce;
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("hold_stable", {found_nonce ^ held_nonce ^ found_hash ^ held_hash},
                    256'(0));
                chk("hold_ctrl", {hash_nonce == held_issue, busy, found_valid, done}, 256'b1110);
            end
            found_ready = 1'b1;
            @(negedge clk);
            chk("match_done", {done, exhausted, found_valid, busy}, 256'b1000);
        end else begin
            chk("exh_found_valid", 256'(fv_cyc), {256{1'b1}});
            chk("exh_done_cycle", 256'(done_cyc), 256'((n == 0) ? 1 : LAT + 1 + n));
            chk("exh_flag", 256'(exhausted), 256'(1));
        end
        @(negedge clk);
        chk("after_done", {done, busy, found_valid}, 256'b000);
        chk("exh_sticky", 256'(exhausted), 256'(idx < 0));
        chk("issue_count", 256'(nonce_log.size()), 256'(n));
        log_ok = 1'b1;
        foreach (nonce_log[i]) if (nonce_log[i] !== b + 256'(i)) log_ok = 1'b0;
        chk("issue_seq", 256'(log_ok), 256'(1));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", {hash_nonce, found_nonce, found_hash} , 256'(0));
        chk("reset_ctrl", {busy, found_valid, done, exhausted}, 256'(0));
        rst_n = 1'b1;

        hmode = 0;
        do_search(256'h1234, 10, 0, 0, 1'b0);
        hmode = 2;
        do_search({$urandom, $urandom, $urandom, $urandom, 128'h0}, 5, 255, 0, 1'b0);
        hmode = 0;
        do_search(256'h9abc_def0_0000_5555, 12, 0, 20, 1'b0);
        hmode = 1;
        do_search({{255{1'b1}}, 1'b0}, 4, 1, 0, 1'b0);
        hmode = 0;
        do_search(256'h77, 0, 3, 0, 1'b0);
        do_search(256'h4000, 30, 2, 0, 1'b1);
        for (int r = 0; r < 5; r++)
            do_search({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                      $urandom_range(1, 40), $urandom_range(0, 4), $urandom_range(0, 6), r[0]);

        @(negedge clk);
        base_nonce = 256'h5000; max_count = 50; difficulty = 8'd255; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_data", {hash_nonce, found_nonce, found_hash}, 256'(0));
        chk("async_reset_ctrl", {busy, found_valid, done, exhausted}, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_reset_idle", {busy, done}, 256'(0));
        end
        do_search(256'hABCD_0000, 16, 1, 2, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
